// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache types: line/address typedefs and the line-to-burst adaptor FSM encoding.
package cacheline_adaptor_pkg;

    typedef logic [255:0] cache_line_t;
    typedef logic [31:0]  pmem_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    localparam int unsigned BURST_BEATS      = 4;
    localparam int unsigned LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_adaptor.sv
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_offset        = 5,
  parameter int unsigned s_line          = 256,
  parameter int unsigned s_burst         = 64,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  output logic               err_o,
`endif
  input  logic               resp_i
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  localparam int unsigned wd_w = ($clog2(WATCHDOG_CYCLES) < 10) ? 10 : $clog2(WATCHDOG_CYCLES);
  localparam logic [wd_w-1:0] wd_limit = wd_w'(WATCHDOG_CYCLES - 1);
  logic [wd_w-1:0] wd, wd_d;
  logic            err_d;
`endif

  state_t             state, state_d;
  logic [cnt_w-1:0]   cnt, cnt_d;
  logic [s_line-1:0]  wbuf, wbuf_d;
  logic [s_line-1:0]  line_d;
  logic [s_burst-1:0] burst_d;
  logic [31:0]        addr_d;
  logic               read_d, write_d, resp_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wbuf_d  = wbuf;
    line_d  = line_o;
    burst_d = burst_o;
    addr_d  = address_o;
    read_d  = read_o;
    write_d = write_o;
    resp_d  = 1'b0;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    wd_d  = '0;
    err_d = err_o;
`endif
    case (state)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i & addr_mask;
          read_d  = 1'b1;
          cnt_d   = '0;
          state_d = RD;
        end else if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = address_i & addr_mask;
          write_d = 1'b1;
          burst_d = line_i[s_burst-1:0];
          cnt_d   = '0;
          state_d = WR;
        end
      end
      RD: begin
        if (resp_i) begin
          line_d[s_burst*cnt +: s_burst] = burst_i;
          cnt_d = cnt + 1'b1;
          if (cnt == last_beat) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt + 1'b1;
          if (cnt == last_beat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            burst_d = wbuf[s_burst*cnt_d +: s_burst];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    // Timeout only fires on a stall cycle, so it never overlaps a beat above.
    if ((state == RD) || (state == WR)) begin
      if (resp_i) begin
        wd_d = '0;
      end else if (wd == wd_limit) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        resp_d  = 1'b1;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        wd_d = wd + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wbuf      <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
      wd        <= '0;
      err_o     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wbuf      <= wbuf_d;
      line_o    <= line_d;
      burst_o   <= burst_d;
      address_o <= addr_d;
      read_o    <= read_d;
      write_o   <= write_d;
      resp_o    <= resp_d;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
      wd        <= wd_d;
      err_o     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  logic         err_o;
`endif

  int unsigned vecs = 0;
  int unsigned errs = 0;

  localparam logic [63:0] A  = 64'hAAAA_0001_AAAA_0001;
  localparam logic [63:0] B  = 64'hBBBB_0002_BBBB_0002;
  localparam logic [63:0] C  = 64'hCCCC_0003_CCCC_0003;
  localparam logic [63:0] D  = 64'hDDDD_0004_DDDD_0004;
  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] W3 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] E0 = 64'hE000_0000_0000_00E0;
  localparam logic [63:0] E1 = 64'hE111_1111_1111_11E1;
  localparam logic [63:0] E2 = 64'hE222_2222_2222_22E2;
  localparam logic [63:0] E3 = 64'hE333_3333_3333_33E3;

  always #5 clk = ~clk;

  cacheline_adaptor #(.WATCHDOG_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    .err_o     (err_o),
`endif
    .resp_i    (resp_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic r, input logic [63:0] d);
    resp_i  = r;
    burst_i = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);

    address_i = 32'h0000_1234; read_i = 1'b1;
    tick();
    chk("rd_read_o", read_o, 1'b1);
    chk("rd_write_o", write_o, 1'b0);
    chk("rd_address_o", address_o, 32'h0000_1220);
    address_i = 32'hFFFF_FFFF;
    beat(1'b0, 64'hDEAD);
    chk("rd_stall_resp", resp_o, 1'b0);
    beat(1'b1, A);
    beat(1'b1, B);
    beat(1'b1, C);
    chk("rd_pre_resp", resp_o, 1'b0);
    chk("rd_read_held", read_o, 1'b1);
    beat(1'b1, D);
    chk("rd_resp", resp_o, 1'b1);
    chk("rd_read_drop", read_o, 1'b0);
    chk("rd_line", line_o, {D, C, B, A});
    chk("rd_addr_latched", address_o, 32'h0000_1220);
    read_i = 1'b0;
    beat(1'b1, 64'hBAD);
    chk("rd_resp_one_cycle", resp_o, 1'b0);
    chk("rd_line_hold", line_o, {D, C, B, A});
    beat(1'b0, '0);

    line_i = {W3, W2, W1, W0}; address_i = 32'h8000_00FF; write_i = 1'b1;
    tick();
    chk("wr_write_o", write_o, 1'b1);
    chk("wr_address_o", address_o, 32'h8000_00E0);
    chk("wr_beat0", burst_o, W0);
    line_i = '1;
    beat(1'b1, '0);
    chk("wr_beat1", burst_o, W1);
    beat(1'b0, '0);
    chk("wr_stall_hold", burst_o, W1);
    beat(1'b1, '0);
    chk("wr_beat2", burst_o, W2);
    beat(1'b1, '0);
    chk("wr_beat3", burst_o, W3);
    chk("wr_write_held", write_o, 1'b1);
    chk("wr_no_early_resp", resp_o, 1'b0);
    beat(1'b1, '0);
    chk("wr_resp", resp_o, 1'b1);
    chk("wr_write_drop", write_o, 1'b0);
    chk("wr_line_untouched", line_o, {D, C, B, A});
    write_i = 1'b0;
    beat(1'b0, '0);
    chk("wr_resp_one_cycle", resp_o, 1'b0);

    address_i = 32'h0000_0040; read_i = 1'b1;
    tick();
    beat(1'b1, E0);
    chk("gap_read_held0", read_o, 1'b1);
    beat(1'b0, 64'h1);
    beat(1'b0, 64'h2);
    chk("gap_read_held1", read_o, 1'b1);
    beat(1'b1, E1);
    beat(1'b1, E2);
    beat(1'b0, 64'h3);
    chk("gap_read_held2", read_o, 1'b1);
    chk("gap_no_early_resp", resp_o, 1'b0);
    beat(1'b1, E3);
    chk("gap_resp", resp_o, 1'b1);
    chk("gap_line", line_o, {E3, E2, E1, E0});
    read_i = 1'b0;
    beat(1'b0, '0);

    line_i = {W0, W1, W2, W3}; address_i = 32'h0000_0100;
    read_i = 1'b1; write_i = 1'b1;
    tick();
    chk("both_read_o", read_o, 1'b1);
    chk("both_write_o", write_o, 1'b0);
    beat(1'b1, D);
    beat(1'b1, C);
    beat(1'b1, B);
    beat(1'b1, A);
    chk("both_resp", resp_o, 1'b1);
    chk("both_line", line_o, {A, B, C, D});
    read_i = 1'b0;
    beat(1'b0, '0);
    chk("both_done_write_idle", write_o, 1'b0);
    tick();
    chk("both_write_next", write_o, 1'b1);
    chk("both_write_beat0", burst_o, W3);
    write_i = 1'b0;
    beat(1'b1, '0);
    beat(1'b1, '0);
    beat(1'b1, '0);
    beat(1'b1, '0);
    chk("both_write_resp", resp_o, 1'b1);
    beat(1'b0, '0);

    address_i = 32'h0000_2000; read_i = 1'b1;
    tick();
    beat(1'b1, A);
    beat(1'b1, B);
    rst = 1'b1;
    beat(1'b0, '0);
    chk("mrst_read_o", read_o, 1'b0);
    chk("mrst_resp_o", resp_o, 1'b0);
    chk("mrst_line_o", line_o, '0);
    chk("mrst_address_o", address_o, '0);
    rst = 1'b0;
    address_i = 32'h0000_303F;
    tick();
    chk("mrst_new_read", read_o, 1'b1);
    chk("mrst_new_addr", address_o, 32'h0000_3020);
    beat(1'b1, W0);
    beat(1'b1, W1);
    beat(1'b1, W2);
    beat(1'b1, W3);
    chk("mrst_new_resp", resp_o, 1'b1);
    chk("mrst_new_line", line_o, {W3, W2, W1, W0});
    read_i = 1'b0;
    beat(1'b0, '0);

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    chk("wd_err_clear", err_o, 1'b0);
    address_i = 32'h0000_4000; read_i = 1'b1;
    tick();
    for (int unsigned i = 0; i < 15; i++) tick();
    chk("wd_no_early_resp", resp_o, 1'b0);
    chk("wd_no_early_err", err_o, 1'b0);
    tick();
    chk("wd_resp", resp_o, 1'b1);
    chk("wd_err", err_o, 1'b1);
    chk("wd_read_drop", read_o, 1'b0);
    read_i = 1'b0;
    tick(); tick();
    chk("wd_err_sticky", err_o, 1'b1);
    chk("wd_resp_once", resp_o, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wd_err_rst", err_o, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
